// File: rtl/m68k_bus_bridge_if.sv
// 68000 CPU bus and memory-controller signal bundle.
// slave = bridge view, master = CPU/memory-side view.
interface m68k_bus_bridge_if;
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        rw;
  logic [22:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_rdata_oe;
  logic        dtack_n;
  logic        cs;
  logic [22:0] addr;
  logic [15:0] data_in;
  logic        high;
  logic        low;
  logic        wr;
  logic [15:0] data_out;

  modport slave (
    input  as_n, uds_n, lds_n, rw,
    input  cpu_addr, cpu_wdata, data_out,
    output cpu_rdata, cpu_rdata_oe, dtack_n,
    output cs, addr, data_in, high, low, wr
  );

  modport master (
    output as_n, uds_n, lds_n, rw,
    output cpu_addr, cpu_wdata, data_out,
    input  cpu_rdata, cpu_rdata_oe, dtack_n,
    input  cs, addr, data_in, high, low, wr
  );
endinterface

// File: rtl/m68k_bus_bridge.sv
// Bridges an asynchronous 68000 bus cycle onto a
// synchronous memory controller with fixed wait states.
module m68k_bus_bridge #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  m68k_bus_bridge_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t     state;
  state_t     state_nx;
  logic [1:0] as_sync;
  logic [1:0] uds_sync;
  logic [1:0] lds_sync;
  logic [1:0] flushed;
  logic       as_s;
  logic       uds_s;
  logic       lds_s;
  logic       armed;
  logic       rd_q;
  logic [3:0] cnt;
  logic       start;
  logic       done;

  assign as_s  = as_sync[1];
  assign uds_s = uds_sync[1];
  assign lds_s = lds_sync[1];

  // Two-flop synchronizers for the strobes, idle-high
  // out of reset; flushed marks when they hold real data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      as_sync  <= 2'b11;
      uds_sync <= 2'b11;
      lds_sync <= 2'b11;
      flushed  <= 2'b00;
    end else begin
      as_sync  <= {as_sync[0], bus.as_n};
      uds_sync <= {uds_sync[0], bus.uds_n};
      lds_sync <= {lds_sync[0], bus.lds_n};
      flushed  <= {flushed[0], 1'b1};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state; abort wins over completion in ACCESS
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && !as_s && (!uds_s || !lds_s)) begin
          start    = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (as_s) begin
          state_nx = IDLE;
        end else if (cnt == 4'd1) begin
          done     = 1'b1;
          state_nx = ACK;
        end
      end
      ACK: begin
        if (as_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A strobe release must be seen before the next cycle
  // may start; ignores reset values still in the syncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     armed <= 1'b0;
    else if (start)              armed <= 1'b0;
    else if (as_s && flushed[1]) armed <= 1'b1;
  end

  // Latch the access, count wait states, drive outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.addr         <= '0;
      bus.data_in      <= '0;
      bus.high         <= 1'b0;
      bus.low          <= 1'b0;
      bus.wr           <= 1'b0;
      bus.cs           <= 1'b0;
      bus.cpu_rdata    <= '0;
      bus.cpu_rdata_oe <= 1'b0;
      bus.dtack_n      <= 1'b1;
      rd_q             <= 1'b0;
      cnt              <= '0;
    end else begin
      if (start) begin
        bus.addr    <= bus.cpu_addr;
        bus.data_in <= bus.cpu_wdata;
        bus.high    <= !uds_s;
        bus.low     <= !lds_s;
        rd_q        <= bus.rw;
        cnt         <= WAIT_LD;
      end else if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
      end
      if (start)                  bus.wr <= !bus.rw;
      else if (state_nx != ACCESS) bus.wr <= 1'b0;
      if (done && rd_q) bus.cpu_rdata <= bus.data_out;
      bus.cs           <= (state_nx == ACCESS);
      bus.dtack_n      <= (state_nx != ACK);
      bus.cpu_rdata_oe <= (state_nx == ACK) && rd_q;
    end
  end

endmodule

// File: tb/tb_m68k_bus_bridge.sv
// Directed bench for m68k_bus_bridge at WAIT_CYCLES 1, 2
// and 15 driven in parallel, with a scoreboard queue.
module tb_m68k_bus_bridge;

  typedef struct {
    logic [22:0] addr;
    logic [15:0] din;
    logic        hi;
    logic        lo;
    logic        wr;
    logic        oe;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        as_n = 1'b1;
  logic        uds_n = 1'b1;
  logic        lds_n = 1'b1;
  logic        rw = 1'b1;
  logic [22:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] data_out = '0;

  int   n_asrt = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  logic [15:0] rdata_m = '0;
  int   wc[3] = '{1, 2, 15};

  m68k_bus_bridge_if i1 ();
  m68k_bus_bridge_if i2 ();
  m68k_bus_bridge_if i15 ();

  assign i1.as_n = as_n;
  assign i1.uds_n = uds_n;
  assign i1.lds_n = lds_n;
  assign i1.rw = rw;
  assign i1.cpu_addr = cpu_addr;
  assign i1.cpu_wdata = cpu_wdata;
  assign i1.data_out = data_out;
  assign i2.as_n = as_n;
  assign i2.uds_n = uds_n;
  assign i2.lds_n = lds_n;
  assign i2.rw = rw;
  assign i2.cpu_addr = cpu_addr;
  assign i2.cpu_wdata = cpu_wdata;
  assign i2.data_out = data_out;
  assign i15.as_n = as_n;
  assign i15.uds_n = uds_n;
  assign i15.lds_n = lds_n;
  assign i15.rw = rw;
  assign i15.cpu_addr = cpu_addr;
  assign i15.cpu_wdata = cpu_wdata;
  assign i15.data_out = data_out;

  m68k_bus_bridge #(.WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .bus(i1)
  );
  m68k_bus_bridge #(.WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .bus(i2)
  );
  m68k_bus_bridge #(.WAIT_CYCLES(15)) u15 (
    .clk(clk), .rst(rst), .bus(i15)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_asrt++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp_v);
    end
  endtask

  task automatic sample(output logic cs_v[3],
                        output logic dt_v[3]);
    cs_v[0] = i1.cs;
    cs_v[1] = i2.cs;
    cs_v[2] = i15.cs;
    dt_v[0] = i1.dtack_n;
    dt_v[1] = i2.dtack_n;
    dt_v[2] = i15.dtack_n;
  endtask

  task automatic xfer(input logic rd,
                      input logic [22:0] a,
                      input logic [15:0] wd,
                      input logic [15:0] dout,
                      input logic u,
                      input logic l,
                      input logic tog);
    exp_t e;
    int   cs_n[3];
    int   dt_k[3];
    logic cs_v[3];
    logic dt_v[3];
    logic seen_cs;
    e.addr  = a;
    e.din   = wd;
    e.hi    = !u;
    e.lo    = !l;
    e.wr    = !rd;
    e.oe    = rd;
    e.rdata = rd ? dout : rdata_m;
    rdata_m = e.rdata;
    sbq.push_back(e);
    data_out  = dout;
    rw        = rd;
    cpu_addr  = a;
    cpu_wdata = wd;
    uds_n     = u;
    lds_n     = l;
    as_n      = 1'b0;
    seen_cs   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cs_n[i] = 0;
      dt_k[i] = -1;
    end
    for (int k = 1; k <= 40; k++) begin
      step();
      sample(cs_v, dt_v);
      for (int i = 0; i < 3; i++) begin
        if (cs_v[i]) cs_n[i]++;
        if (!dt_v[i] && dt_k[i] < 0) dt_k[i] = k;
      end
      if (i2.cs && !seen_cs) begin
        seen_cs = 1'b1;
        e = sbq[0];
        chk("addr", 32'(i2.addr), 32'(e.addr));
        chk("data_in", 32'(i2.data_in), 32'(e.din));
        chk("high", 32'(i2.high), 32'(e.hi));
        chk("low", 32'(i2.low), 32'(e.lo));
        chk("wr", 32'(i2.wr), 32'(e.wr));
        if (tog) uds_n = !uds_n;
      end
      if (!i2.dtack_n && dt_k[1] == k) begin
        e = sbq.pop_front();
        chk("rdata", 32'(i2.cpu_rdata), 32'(e.rdata));
        chk("oe_ack", 32'(i2.cpu_rdata_oe), 32'(e.oe));
        chk("high_ack", 32'(i2.high), 32'(e.hi));
        chk("wr_ack", 32'(i2.wr), 32'd0);
        chk("cs_ack", 32'(i2.cs), 32'd0);
      end
      if (dt_k[0] > 0 && dt_k[1] > 0 && dt_k[2] > 0) break;
    end
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cs_width_w%0d", wc[i]),
          32'(cs_n[i]), 32'(wc[i]));
      chk($sformatf("latency_w%0d", wc[i]),
          32'(dt_k[i] - 2), 32'(wc[i] + 1));
    end
    chk("hold_dtack", 32'(i2.dtack_n), 32'd0);
    chk("hold_oe", 32'(i2.cpu_rdata_oe), 32'(rd));
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (i2.dtack_n) begin
        chk("rel_edge", 32'(k), 32'd3);
        chk("rel_oe", 32'(i2.cpu_rdata_oe), 32'd0);
        break;
      end
    end
    chk("released", 32'(i2.dtack_n), 32'd1);
    repeat (3) step();
  endtask

  initial begin
    int   cs_n[3];
    int   dt_n[3];
    logic cs_v[3];
    logic dt_v[3];

    step();
    chk("rst_cs", 32'(i2.cs), 32'd0);
    chk("rst_wr", 32'(i2.wr), 32'd0);
    chk("rst_dtack", 32'(i2.dtack_n), 32'd1);
    chk("rst_oe", 32'(i2.cpu_rdata_oe), 32'd0);
    chk("rst_hilo", 32'({i2.high, i2.low}), 32'd0);
    chk("rst_addr", 32'(i2.addr), 32'd0);
    chk("rst_din", 32'(i2.data_in), 32'd0);
    chk("rst_rdata", 32'(i2.cpu_rdata), 32'd0);
    rst = 1'b0;
    repeat (4) step();

    xfer(1'b1, 23'h7F8000, 16'h0000, 16'hBEEF,
         1'b0, 1'b0, 1'b0);
    xfer(1'b0, 23'h000010, 16'h00A5, 16'h3C3C,
         1'b1, 1'b0, 1'b0);

    data_out  = 16'hDEAD;
    rw        = 1'b1;
    cpu_addr  = 23'h000123;
    uds_n     = 1'b0;
    lds_n     = 1'b0;
    as_n      = 1'b0;
    step();
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cs_n[i] = 0;
      dt_n[i] = 0;
    end
    for (int k = 2; k <= 20; k++) begin
      step();
      sample(cs_v, dt_v);
      for (int i = 0; i < 3; i++) begin
        if (cs_v[i]) cs_n[i]++;
        if (!dt_v[i]) dt_n[i]++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_cs_w%0d", wc[i]),
          32'(cs_n[i]), 32'd1);
      chk($sformatf("abort_dtack_w%0d", wc[i]),
          32'(dt_n[i]), 32'd0);
    end
    chk("abort_rdata_w2", 32'(i2.cpu_rdata), 32'(rdata_m));
    chk("abort_rdata_w1", 32'(i1.cpu_rdata), 32'(rdata_m));
    chk("abort_wr", 32'(i2.wr), 32'd0);

    data_out = 16'h1234;
    rw       = 1'b1;
    cpu_addr = 23'h000200;
    uds_n    = 1'b0;
    lds_n    = 1'b0;
    as_n     = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (!i2.dtack_n) break;
    end
    chk("ack_reached", 32'(i2.dtack_n), 32'd0);
    chk("ack_oe", 32'(i2.cpu_rdata_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_dtack", 32'(i2.dtack_n), 32'd1);
    chk("arst_oe", 32'(i2.cpu_rdata_oe), 32'd0);
    chk("arst_cs_w15", 32'(i15.cs), 32'd0);
    chk("arst_rdata", 32'(i2.cpu_rdata), 32'd0);
    rdata_m = '0;
    #2;
    rst = 1'b0;
    cs_n[1] = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (i2.cs) cs_n[1]++;
    end
    chk("no_restart", 32'(cs_n[1]), 32'd0);
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    repeat (4) step();
    xfer(1'b1, 23'h000200, 16'h0000, 16'h1234,
         1'b0, 1'b0, 1'b0);

    xfer(1'b1, 23'h055AA5, 16'h0000, 16'h5A5A,
         1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/m68k_bus_bridge.md
M68K_BUS_BRIDGE -- requirements
Module: m68k_bus_bridge

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of clk cycles cs is held before data capture and acknowledge; legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 as_n  input  1  CPU address strobe, active low, asynchronous to clk.
REQ-005 uds_n  input  1  CPU upper data strobe, active low, asynchronous.
REQ-006 lds_n  input  1  CPU lower data strobe, active low, asynchronous.
REQ-007 rw  input  1  CPU read/write; 1 = read, 0 = write.
REQ-008 cpu_addr  input  23  CPU word address bits [23:1].
REQ-009 cpu_wdata  input  16  CPU write data.
REQ-010 cpu_rdata  output  16  read data returned to CPU.
REQ-011 cpu_rdata_oe  output  1  CPU data bus drive enable.
REQ-012 dtack_n  output  1  data transfer acknowledge to CPU, active low.
REQ-013 cs  output  1  memory-controller select.
REQ-014 addr  output  23  latched word address [23:1] to memory controller.
REQ-015 data_in  output  16  latched write data to memory controller.
REQ-016 high  output  1  upper byte enable (from uds_n).
REQ-017 low  output  1  lower byte enable (from lds_n).
REQ-018 wr  output  1  write enable to memory controller.
REQ-019 data_out  input  16  read data from memory controller, valid one cycle after address/cs stable.

Function
REQ-020 as_n, uds_n, lds_n shall each pass through a two-flop synchronizer; FSM uses synchronized versions only; rw, cpu_addr, cpu_wdata sampled unsynchronized at the qualifying edge (stable by bus protocol).
REQ-021 FSM states: IDLE, ACCESS, ACK.
REQ-022 IDLE: when synced as_n = 0 and (synced uds_n = 0 or synced lds_n = 0), latch addr, data_in, high = !uds_n, low = !lds_n, wr = !rw; load wait counter with WAIT_CYCLES; next state ACCESS.
REQ-023 ACCESS: cs = 1 and wr held stable for exactly WAIT_CYCLES cycles; counter decrements each cycle.
REQ-024 On the final ACCESS cycle (counter = 1), cpu_rdata shall capture data_out if the latched access is a read; unchanged on writes; next state ACK.
REQ-025 ACK: cs = 0, wr = 0, dtack_n = 0, cpu_rdata_oe = 1 for reads, 0 for writes; remain until synced as_n = 1.
REQ-026 ACK exit: on synced as_n = 1, dtack_n = 1 and cpu_rdata_oe = 0 in the same clock edge; next state IDLE.
REQ-027 Abort: synced as_n = 1 during ACCESS shall drop cs and wr on the next edge, return to IDLE, never assert dtack_n, leave cpu_rdata unchanged.
REQ-028 A new access shall not start until as_n has been seen deasserted in IDLE or ACK (no back-to-back without strobe release).
REQ-029 Strobe changes after the qualifying edge shall not alter latched high/low for the current access.
REQ-030 Total read latency, qualifying synced edge to dtack_n = 0: WAIT_CYCLES + 1 cycles.

Reset
REQ-031 While rst = 1 all state clears immediately: FSM = IDLE, synchronizers = 1 (inactive), cs = 0, wr = 0, high = 0, low = 0, addr = 0, data_in = 0, cpu_rdata = 0, cpu_rdata_oe = 0, dtack_n = 1.
REQ-032 rst asserted mid-ACCESS or mid-ACK shall drop cs and release dtack_n asynchronously; after release the block waits for a fresh as_n assertion.

Verification
REQ-033 Word read, WAIT_CYCLES = 2, addr 0x7F8000, data_out = 0xBEEF -> cs high 2 cycles, dtack_n low 3 cycles after synced strobes, cpu_rdata = 0xBEEF, oe = 1 until as_n rises.
REQ-034 Byte write, lds_n only, cpu_wdata = 0x00A5, addr 0x000010 -> wr = 1, low = 1, high = 0, data_in = 0x00A5 for 2 cycles, dtack_n low, oe = 0.
REQ-035 Abort: as_n deasserted after 1 ACCESS cycle -> cs drops next edge, dtack_n never asserts, FSM IDLE.
REQ-036 rst pulse during ACK -> dtack_n = 1 and oe = 0 immediately; held as_n low afterward does not restart an access until released and reasserted.
REQ-037 WAIT_CYCLES = 1 and 15 sweep -> cs width equals parameter exactly; latency WAIT_CYCLES + 1.
REQ-038 uds_n toggled during ACCESS -> high keeps latched value; access completes normally.
